adc_clkgen: RTL and testbench
=============================

# adc_clkgen

Parametrised ADC clock generator driven by a single fast reference clock. It produces NUM_CH registered, divided clock outputs, each with its own runtime-programmable divisor and phase offset, plus a `locked` indication. It replaces the fixed three-output PLL front end for the ADC path and sits between the PLL's fast output and the ADC sample/capture logic. Configuration is staged in shadow registers and applied atomically, so all channels realign on one edge.

## Interface
- `NUM_CH`, default 3: number of output channels (1..16).
- `DIV_W`, default 8: divisor/phase field width.
- `DEFAULT_DIV`, default 6: reset divisor for every channel.
- `LOCK_CYCLES`, default 16: refclk cycles from realignment to `locked` (≥1).
- `refclk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: configuration write request.
- `cfg_ready` out 1: write can be accepted this cycle.
- `cfg_chan` in $clog2(NUM_CH): target channel.
- `cfg_div` in DIV_W: divisor.
- `cfg_phase` in DIV_W: phase offset, in refclk cycles.
- `cfg_apply` in 1: one-cycle pulse; copy shadow to active and realign.
- `outclk` out NUM_CH: divided clocks, one bit per channel.
- `locked` out 1: outputs are running with the current active configuration.

## Operation
- **Shadow registers (per channel):**
  - A write is accepted when `cfg_valid && cfg_ready`.
  - A write with `cfg_chan >= NUM_CH` is accepted and discarded.
- **Sanitising on apply:**
  - Effective divisor = max(div, 2).
  - Phase ≥ effective divisor is clamped to divisor−1.
- **Per-channel counter `cnt`:**
  - Counts 0..div−1 and wraps to 0.
  - `outclk[i]` is registered high when the next `cnt` < div>>1, so it is high for floor(div/2) cycles. Example: div=6 gives 3 high/3 low; div=3 gives 1 high/2 low.
- **Realignment:** every channel loads `cnt` with (div−phase) mod div. Its first rising edge therefore lands `phase` cycles after realignment.
- **FSM states:**
  - RESET → ALIGN (first clock after `rst` deasserts).
  - ALIGN (1 cycle): load active config, load counters, hold outputs low, `cfg_ready`=0 → RUN_WAIT.
  - RUN_WAIT: counters run; a lock counter counts to LOCK_CYCLES → LOCKED.
  - LOCKED: `locked`=1.
  - `cfg_apply` in RUN_WAIT or LOCKED → ALIGN; `locked` drops on the next edge.
- **Write and apply in the same cycle:** the accepted write is included in the applied config.
- **`cfg_apply` during ALIGN:** ignored, since `cfg_ready`=0 and realignment is already in progress.

## Timing
- **Reset values:**
  - `outclk`=0, `locked`=0, `cfg_ready`=0.
  - All divisors = DEFAULT_DIV, phases = 0.
  - FSM in RESET.
- **`rst` mid-operation:** all state is returned to reset values asynchronously.
- **`cfg_ready`:** 1 in RUN_WAIT and LOCKED.
- **Apply latency:** `cfg_apply` sampled at edge N → ALIGN at N+1, `locked`=0 from N+1.
- **First output edge:** the first `outclk[i]` rising edge (for phase p) is at N+2+p.
- **Lock latency:** `locked` rises LOCK_CYCLES edges after the ALIGN cycle.
- **Glitch-free outputs:** every `outclk` bit comes straight from a flop, with no combinational path from inputs.

## Configuration
- **`ADC_CLKGEN_STROBE_EN` defined:**
  - Adds output `outstb` [NUM_CH], a registered one-cycle pulse coincident with each `outclk[i]` rising edge.
  - `outstb` resets to 0 and is forced to 0 during ALIGN.
- **Not defined:** the `outstb` port and its logic are absent; all other behaviour is identical.

## Structure
- **Package `adc_clkgen_pkg`:**
  - FSM state enum {RESET, ALIGN, RUN_WAIT, LOCKED}.
  - `MIN_DIV`=2 constant.
  - Divisor/phase sanitise function.
- **Sub-module `adc_clkgen_chan`:** one counter + output flop (+ strobe), instantiated NUM_CH times by generate. The top level holds the shadow registers, active registers, FSM and lock counter.

## Test plan
- Reset release, defaults (DEFAULT_DIV=6) → all `outclk` 3 high/3 low, in phase; `locked` rises 16 cycles after ALIGN; `cfg_ready`=1 from RUN_WAIT.
- Write ch1 div=6 phase=2, ch2 div=1, then apply → `locked` drops next edge; ch1 rises 2 cycles after ch0; ch2 toggles every cycle (div clamped to 2).
- Write ch0 div=5 phase=9, apply → phase clamped to 4; period 5, high 2 cycles.
- Write ch2 and pulse `cfg_apply` in the same cycle → new ch2 value takes effect; a second apply during ALIGN is ignored; `cfg_chan`=3 write is discarded.
- Assert `rst` while LOCKED → `outclk`/`locked` go 0 immediately, without a clock edge; recovery repeats the defaults scenario.
- With `ADC_CLKGEN_STROBE_EN`: each `outstb` pulse is exactly 1 cycle wide and aligned to an `outclk` rise; no pulse during ALIGN.

Source files
------------

// File: rtl/adc_clkgen_pkg.sv
// adc_clkgen_pkg: FSM states, minimum divisor and divisor/phase sanitising shared by the clock generator.
package adc_clkgen_pkg;
  typedef enum logic [1:0] {RESET, ALIGN, RUN_WAIT, LOCKED} state_t;
  localparam int unsigned MIN_DIV = 2;
  function automatic int unsigned eff_div(input int unsigned d);
    return d < MIN_DIV ? MIN_DIV : d;
  endfunction
  function automatic int unsigned eff_phase(input int unsigned d, input int unsigned p);
    return p >= eff_div(d) ? eff_div(d) - 1 : p;
  endfunction
endpackage

// File: rtl/adc_clkgen_if.sv
// adc_clkgen_if: configuration write/apply port of the ADC clock generator.
interface adc_clkgen_if #(parameter int NUM_CH = 3, parameter int DIV_W = 8);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic cfg_valid;
  logic cfg_ready;
  logic [CH_W-1:0] cfg_chan;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic cfg_apply;
  modport master(output cfg_valid, cfg_chan, cfg_div, cfg_phase, cfg_apply, input cfg_ready);
  modport slave(input cfg_valid, cfg_chan, cfg_div, cfg_phase, cfg_apply, output cfg_ready);
endinterface

// File: rtl/adc_clkgen_chan.sv
// adc_clkgen_chan: one divided-clock channel (counter + output flop); strobe output when ADC_CLKGEN_STROBE_EN is defined.
module adc_clkgen_chan #(
  parameter int DIV_W = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] ld_div,
  input  logic [DIV_W-1:0] ld_ph,
  output logic             outclk
`ifdef ADC_CLKGEN_STROBE_EN
  ,
  output logic             outstb
`endif
);
  logic [DIV_W-1:0] cnt, cnt_nxt, start;
  logic run, run_nxt, out_nxt;
  // run stays low after a phased realignment until cnt wraps, so no runt pulse precedes the first rise
  always_comb begin
    start = ld_ph == '0 ? '0 : ld_div - ld_ph;
    cnt_nxt = load ? start : (cnt == div - 1'b1 ? '0 : cnt + 1'b1);
    run_nxt = (!load && run) || cnt_nxt == '0;
    out_nxt = !clr && run_nxt && (cnt_nxt < ((load ? ld_div : div) >> 1));
  end
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
      outclk <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      run <= run_nxt;
      outclk <= out_nxt;
    end
`ifdef ADC_CLKGEN_STROBE_EN
  always_ff @(posedge refclk or posedge rst)
    if (rst) outstb <= 1'b0;
    else outstb <= out_nxt && !outclk;
`endif
endmodule

// File: rtl/adc_clkgen.sv
// adc_clkgen: NUM_CH programmable divided clocks from refclk with atomic apply and lock indication.
// Optional per-channel rising-edge strobe outstb when ADC_CLKGEN_STROBE_EN is defined.
module adc_clkgen
  import adc_clkgen_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 6,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              rst,
  adc_clkgen_if.slave       cfg,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
`ifdef ADC_CLKGEN_STROBE_EN
  ,
  output logic [NUM_CH-1:0] outstb
`endif
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int LC_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  state_t state, state_nxt;
  logic [LC_W-1:0] lock_cnt;
  logic wr, clr, load;
  assign wr = cfg.cfg_valid && cfg.cfg_ready;
  always_ff @(posedge refclk or posedge rst)
    if (rst) state <= RESET;
    else state <= state_nxt;
  always_comb
    state_nxt = state == RESET ? ALIGN :
                state == ALIGN ? RUN_WAIT :
                cfg.cfg_apply ? ALIGN :
                (state == RUN_WAIT && lock_cnt == LC_W'(LOCK_CYCLES - 1)) ? LOCKED : state;
  always_comb begin
    cfg.cfg_ready = state == RUN_WAIT || state == LOCKED;
    locked = state == LOCKED;
    clr = state_nxt == ALIGN;
    load = state == ALIGN;
  end
  always_ff @(posedge refclk or posedge rst)
    if (rst) lock_cnt <= '0;
    else lock_cnt <= state == RUN_WAIT ? lock_cnt + 1'b1 : '0;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] sh_div, sh_ph, act_div, ld_div, ld_ph;
    assign ld_div = DIV_W'(eff_div(32'(sh_div)));
    assign ld_ph = DIV_W'(eff_phase(32'(sh_div), 32'(sh_ph)));
    // writes to cfg_chan >= NUM_CH match no channel and vanish
    always_ff @(posedge refclk or posedge rst)
      if (rst) begin
        sh_div <= RST_DIV;
        sh_ph <= '0;
        act_div <= RST_DIV;
      end else begin
        if (wr && cfg.cfg_chan == CH_W'(i)) begin
          sh_div <= cfg.cfg_div;
          sh_ph <= cfg.cfg_phase;
        end
        if (load) act_div <= ld_div;
      end
    adc_clkgen_chan #(.DIV_W(DIV_W)) u_chan (
      .refclk(refclk),
      .rst(rst),
      .clr(clr),
      .load(load),
      .div(act_div),
      .ld_div(ld_div),
      .ld_ph(ld_ph),
      .outclk(outclk[i])
`ifdef ADC_CLKGEN_STROBE_EN
      ,
      .outstb(outstb[i])
`endif
    );
  end
endmodule

// File: tb/tb_adc_clkgen.sv
// tb_adc_clkgen: table-driven check of adc_clkgen divisors, phases, lock timing, apply corners and async reset.
module tb_adc_clkgen;
  localparam int W = 40;
  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] outclk;
  logic locked;
  always #5 refclk = ~refclk;
  adc_clkgen_if #(.NUM_CH(3), .DIV_W(8)) cfg ();
`ifdef ADC_CLKGEN_STROBE_EN
  logic [2:0] outstb;
  logic [2:0] shist[W];
`endif
  adc_clkgen #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(6), .LOCK_CYCLES(16)) dut (
    .refclk(refclk),
    .rst(rst),
    .cfg(cfg),
    .outclk(outclk),
    .locked(locked)
`ifdef ADC_CLKGEN_STROBE_EN
    ,
    .outstb(outstb)
`endif
  );
  typedef struct {
    int ch;
    int div;
    int ph;
    int per;
    int high;
    int dly;
  } vec_t;
  vec_t vecs[6];
  int checks = 0;
  int failures = 0;
  int e_per[3], e_high[3], e_dly[3];
  logic [2:0] hist[W];
  logic lk[W], rdy[W];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic write(input int ch, input int d, input int p);
    logic [1:0] c;
    logic [7:0] dv, pv;
    c = ch[1:0];
    dv = d[7:0];
    pv = p[7:0];
    cfg.cfg_valid = 1'b1;
    cfg.cfg_chan = c;
    cfg.cfg_div = dv;
    cfg.cfg_phase = pv;
    check($sformatf("ready_wr ch%0d", ch), cfg.cfg_ready, 1);
    @(negedge refclk);
    cfg.cfg_valid = 1'b0;
  endtask
  task automatic set_defaults();
    for (int c = 0; c < 3; c++) begin
      e_per[c] = 6;
      e_high[c] = 3;
      e_dly[c] = 1;
    end
  endtask
  task automatic measure(input string tag, input logic again);
    int fl, r1, r2, hi;
`ifdef ADC_CLKGEN_STROBE_EN
    int se;
`endif
    for (int k = 0; k < W; k++) begin
      hist[k] = outclk;
      lk[k] = locked;
      rdy[k] = cfg.cfg_ready;
`ifdef ADC_CLKGEN_STROBE_EN
      shist[k] = outstb;
`endif
      cfg.cfg_apply = (k == 0) ? again : 1'b0;
      @(negedge refclk);
    end
    check({tag, " align_out"}, hist[0], 0);
    check({tag, " align_ready"}, rdy[0], 0);
    check({tag, " align_locked"}, lk[0], 0);
    check({tag, " run_ready"}, rdy[1], 1);
    fl = -1;
    for (int k = 0; k < W; k++) if (lk[k] && fl < 0) fl = k;
    check({tag, " lock_cycle"}, fl, 17);
    for (int c = 0; c < 3; c++) begin
      r1 = -1;
      r2 = -1;
      hi = 0;
      for (int k = 0; k < W; k++) if (hist[k][c] && r1 < 0) r1 = k;
      if (r1 >= 0) while (r1 + hi < W && hist[r1+hi][c]) hi++;
      if (r1 >= 0) for (int k = r1 + hi; k < W; k++) if (hist[k][c] && r2 < 0) r2 = k;
      check($sformatf("%s ch%0d first_rise", tag, c), r1, e_dly[c]);
      check($sformatf("%s ch%0d high", tag, c), hi, e_high[c]);
      check($sformatf("%s ch%0d period", tag, c), (r1 >= 0 && r2 >= 0) ? r2 - r1 : -1, e_per[c]);
    end
`ifdef ADC_CLKGEN_STROBE_EN
    se = (shist[0] != 3'b000) ? 1 : 0;
    for (int k = 1; k < W; k++) if (shist[k] !== (hist[k] & ~hist[k-1])) se++;
    check({tag, " strobe_errors"}, se, 0);
`endif
  endtask
  initial begin
    vecs[0] = '{ch: 1, div: 6, ph: 2, per: 6, high: 3, dly: 3};
    vecs[1] = '{ch: 2, div: 1, ph: 0, per: 2, high: 1, dly: 1};
    vecs[2] = '{ch: 0, div: 5, ph: 9, per: 5, high: 2, dly: 5};
    vecs[3] = '{ch: 1, div: 3, ph: 1, per: 3, high: 1, dly: 2};
    vecs[4] = '{ch: 2, div: 7, ph: 0, per: 7, high: 3, dly: 1};
    vecs[5] = '{ch: 0, div: 0, ph: 0, per: 2, high: 1, dly: 1};
    cfg.cfg_valid = 1'b0;
    cfg.cfg_chan = '0;
    cfg.cfg_div = '0;
    cfg.cfg_phase = '0;
    cfg.cfg_apply = 1'b0;
    repeat (3) @(negedge refclk);
    check("reset outclk", outclk, 0);
    check("reset locked", locked, 0);
    check("reset ready", cfg.cfg_ready, 0);
    rst = 1'b0;
    @(negedge refclk);
    set_defaults();
    measure("defaults", 1'b0);
    for (int v = 0; v < 6; v++) begin
      write(vecs[v].ch, vecs[v].div, vecs[v].ph);
      check($sformatf("vec%0d pre_locked", v), locked, 1);
      cfg.cfg_apply = 1'b1;
      @(negedge refclk);
      e_per[vecs[v].ch] = vecs[v].per;
      e_high[vecs[v].ch] = vecs[v].high;
      e_dly[vecs[v].ch] = vecs[v].dly;
      measure($sformatf("vec%0d", v), 1'b0);
    end
    write(3, 9, 0);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_chan = 2'd2;
    cfg.cfg_div = 8'd4;
    cfg.cfg_phase = 8'd1;
    cfg.cfg_apply = 1'b1;
    @(negedge refclk);
    cfg.cfg_valid = 1'b0;
    e_per[2] = 4;
    e_high[2] = 2;
    e_dly[2] = 2;
    measure("wr_apply", 1'b1);
    for (int i = 0; i < 20 && outclk == 3'b000; i++) @(negedge refclk);
    check("rst pre_out_nonzero", outclk != 3'b000, 1);
    check("rst pre_locked", locked, 1);
    #2 rst = 1'b1;
    #1;
    check("async outclk", outclk, 0);
    check("async locked", locked, 0);
    check("async ready", cfg.cfg_ready, 0);
    @(negedge refclk);
    @(negedge refclk);
    rst = 1'b0;
    @(negedge refclk);
    set_defaults();
    measure("recover", 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
